// File: rtl/bitserial_logic_unit.sv
// Bit-serial AND/OR/XOR/NOR unit: processes DIGIT bits per cycle, LSB first, and
// returns the full word with zero/parity flags over a valid/ready handshake.
module bitserial_logic_unit #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_parity
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("bitserial_logic_unit: WIDTH must be a positive multiple of DIGIT");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  typedef enum logic [1:0] {OP_AND = 2'b00, OP_OR = 2'b01, OP_XOR = 2'b10, OP_NOR = 2'b11} op_e;

  state_e           state_q;
  op_e              op_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [CW-1:0]    count_q;
  logic             zero_acc_q, par_acc_q;
  logic             out_valid_q, out_zero_q, out_parity_q;
  logic [WIDTH-1:0] out_result_q;

  logic [DIGIT-1:0] digit_d;
  logic [WIDTH-1:0] a_d, b_d, res_d;
  logic             zero_d, par_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    digit_d = '0;
    case (op_q)
      OP_AND: digit_d = a_q[DIGIT-1:0] & b_q[DIGIT-1:0];
      OP_OR:  digit_d = a_q[DIGIT-1:0] | b_q[DIGIT-1:0];
      OP_XOR: digit_d = a_q[DIGIT-1:0] ^ b_q[DIGIT-1:0];
      OP_NOR: digit_d = ~(a_q[DIGIT-1:0] | b_q[DIGIT-1:0]);
      default: digit_d = '0;
    endcase
    a_d    = a_q >> DIGIT;
    b_d    = b_q >> DIGIT;
    // The result fills from the MSB end so the first digit lands in bit 0 after N shifts.
    res_d  = (res_q >> DIGIT) | (WIDTH'(digit_d) << (WIDTH - DIGIT));
    zero_d = zero_acc_q & (digit_d == '0);
    par_d  = par_acc_q ^ (^digit_d);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order in this block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= OP_AND;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      count_q      <= '0;
      zero_acc_q   <= 1'b1;
      par_acc_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_zero_q   <= 1'b0;
      out_parity_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q        <= in_a;
            b_q        <= in_b;
            op_q       <= op_e'(in_op);
            count_q    <= '0;
            zero_acc_q <= 1'b1;
            par_acc_q  <= 1'b0;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          a_q        <= a_d;
          b_q        <= b_d;
          res_q      <= res_d;
          zero_acc_q <= zero_d;
          par_acc_q  <= par_d;
          if (count_q == LAST) begin
            count_q      <= '0;
            state_q      <= S_DONE;
            out_valid_q  <= 1'b1;
            out_result_q <= res_d;
            out_zero_q   <= zero_d;
            out_parity_q <= par_d;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_zero   = out_zero_q;
  assign out_parity = out_parity_q;

endmodule

// File: tb/tb_bitserial_logic_unit.sv
// Directed bench for bitserial_logic_unit: default DIGIT=1 instance plus a DIGIT=4 instance.
module tb_bitserial_logic_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_zero, out_parity;
  logic [1:0]  in_op;
  logic [15:0] in_a, in_b, out_result;

  logic        d4_in_valid, d4_in_ready, d4_out_valid, d4_out_ready, d4_out_zero, d4_out_parity;
  logic [1:0]  d4_in_op;
  logic [15:0] d4_in_a, d4_in_b, d4_out_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bitserial_logic_unit #(.WIDTH(16), .DIGIT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_parity(out_parity)
  );

  bitserial_logic_unit #(.WIDTH(16), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d4_in_valid), .in_ready(d4_in_ready), .in_op(d4_in_op), .in_a(d4_in_a), .in_b(d4_in_b),
    .out_valid(d4_out_valid), .out_ready(d4_out_ready), .out_result(d4_out_result),
    .out_zero(d4_out_zero), .out_parity(d4_out_parity)
  );

  // Present a command at a falling edge; returns at the falling edge after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts rising edges from the accepting edge until out_valid is seen (bounded).
  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b1; in_op = 2'b00; in_a = 16'hFFFF; in_b = 16'hFFFF; out_ready = 1'b0;
    d4_in_valid = 1'b0; d4_in_op = 2'b00; d4_in_a = '0; d4_in_b = '0; d4_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_result !== 16'h0000) begin errors++; $display("FAIL reset_out_result got %h exp 0000", out_result); end
    checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL reset_out_zero got %b exp 0", out_zero); end
    checks++; if (out_parity !== 1'b0) begin errors++; $display("FAIL reset_out_parity got %b exp 0", out_parity); end
    checks++; if (d4_out_valid !== 1'b0) begin errors++; $display("FAIL reset_d4_out_valid got %b exp 0", d4_out_valid); end
    // A command held during reset must not have been accepted.
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL reset_no_accept got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
      end
    end
  endtask

  task automatic test_and;
    int lat;
    issue(2'b00, 16'hF0F0, 16'hFF00);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL and_busy_ready got %b exp 0", in_ready); end
    wait_valid(lat);
    checks++; if (lat != 16) begin errors++; $display("FAIL and_latency got %0d exp 16", lat); end
    checks++; if (out_result !== 16'hF000) begin errors++; $display("FAIL and_result got %h exp f000", out_result); end
    checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL and_zero got %b exp 0", out_zero); end
    checks++; if (out_parity !== 1'b0) begin errors++; $display("FAIL and_parity got %b exp 0", out_parity); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL and_take_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL and_take_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_xor_nor;
    int lat;
    logic [1:0]  ops [3];
    logic [15:0] as [3], bs [3], exp_r [3];
    logic        exp_z [3], exp_p [3];
    ops = '{2'b10, 2'b11, 2'b10};
    as  = '{16'hAAAA, 16'hFFFF, 16'h1234};
    bs  = '{16'hAAAA, 16'h0000, 16'h00FF};
    exp_r = '{16'h0000, 16'h0000, 16'h12CB};
    exp_z = '{1'b1, 1'b1, 1'b0};
    exp_p = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_valid(lat);
      checks++; if (lat != 16) begin errors++; $display("FAIL xn%0d_latency got %0d exp 16", i, lat); end
      checks++; if (out_result !== exp_r[i]) begin errors++; $display("FAIL xn%0d_result got %h exp %h", i, out_result, exp_r[i]); end
      checks++; if (out_zero !== exp_z[i]) begin errors++; $display("FAIL xn%0d_zero got %b exp %b", i, out_zero, exp_z[i]); end
      checks++; if (out_parity !== exp_p[i]) begin errors++; $display("FAIL xn%0d_parity got %b exp %b", i, out_parity, exp_p[i]); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure;
    int lat;
    issue(2'b01, 16'h0001, 16'h0002);
    wait_valid(lat);
    checks++; if (lat != 16) begin errors++; $display("FAIL bp_latency got %0d exp 16", lat); end
    for (int i = 0; i < 5; i++) begin
      // A competing command appears mid-stall and stays asserted.
      if (i == 2) begin
        in_op = 2'b00; in_a = 16'hFFFF; in_b = 16'hFFFF; in_valid = 1'b1;
      end
      checks++;
      if (out_valid !== 1'b1 || out_result !== 16'h0003 || out_zero !== 1'b0 || out_parity !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b r=%h z=%b p=%b rdy=%b exp v=1 r=0003 z=0 p=0 rdy=0",
                 i, out_valid, out_result, out_zero, out_parity, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_take_valid got %b exp 0", out_valid); end
    checks++; if (out_result !== 16'h0003) begin errors++; $display("FAIL bp_keep_result got %h exp 0003", out_result); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_take_ready got %b exp 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept got ready=%b exp 0", in_ready); end
    wait_valid(lat);
    checks++; if (lat != 16) begin errors++; $display("FAIL bp2_latency got %0d exp 16", lat); end
    checks++; if (out_result !== 16'hFFFF) begin errors++; $display("FAIL bp2_result got %h exp ffff", out_result); end
    checks++; if (out_parity !== 1'b0 || out_zero !== 1'b0) begin
      errors++; $display("FAIL bp2_flags got z=%b p=%b exp z=0 p=0", out_zero, out_parity);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_abort;
    int lat;
    issue(2'b00, 16'hFFFF, 16'hFFFF);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b exp 1", in_ready); end
    repeat (20) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_no_valid got %b exp 0", out_valid); end
    end
    issue(2'b01, 16'h8001, 16'h0100);
    wait_valid(lat);
    checks++; if (lat != 16) begin errors++; $display("FAIL abort_or_latency got %0d exp 16", lat); end
    checks++; if (out_result !== 16'h8101) begin errors++; $display("FAIL abort_or_result got %h exp 8101", out_result); end
    checks++; if (out_parity !== 1'b1 || out_zero !== 1'b0) begin
      errors++; $display("FAIL abort_or_flags got z=%b p=%b exp z=0 p=1", out_zero, out_parity);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_digit4;
    int lat;
    checks++; if (d4_in_ready !== 1'b1) begin errors++; $display("FAIL d4_ready got %b exp 1", d4_in_ready); end
    d4_in_op = 2'b01; d4_in_a = 16'h1234; d4_in_b = 16'h0F0F; d4_in_valid = 1'b1;
    @(negedge clk);
    d4_in_valid = 1'b0;
    lat = 0;
    while (d4_out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat != 4) begin errors++; $display("FAIL d4_latency got %0d exp 4", lat); end
    checks++; if (d4_out_result !== 16'h1F3F) begin errors++; $display("FAIL d4_result got %h exp 1f3f", d4_out_result); end
    checks++; if (d4_out_parity !== 1'b1) begin errors++; $display("FAIL d4_parity got %b exp 1", d4_out_parity); end
    checks++; if (d4_out_zero !== 1'b0) begin errors++; $display("FAIL d4_zero got %b exp 0", d4_out_zero); end
    d4_out_ready = 1'b1;
    @(negedge clk);
    d4_out_ready = 1'b0;
    checks++; if (d4_out_valid !== 1'b0 || d4_in_ready !== 1'b1) begin
      errors++; $display("FAIL d4_take got v=%b rdy=%b exp v=0 rdy=1", d4_out_valid, d4_in_ready);
    end
  endtask

  initial begin
    test_reset;
    test_and;
    test_xor_nor;
    test_backpressure;
    test_abort;
    test_digit4;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
